brownout_seq: RTL
=================

Name: brownout_seq

Overview:
Digital sequencer sitting between the SoC/config interface and the brownout macro's trip-code, enable and output path. It applies otrip/vtrip codes through a valid/ready handshake and blanks the comparator path while the analog settles after enable or a code change. It stretches every brownout event by a minimum hold time and counts events with a sticky interrupt. Runs on the macro's oscillator clock osc_ck.

Parameters:
SETTLE_CYC, 64, cycles of blanking after ena rises (>=1)
HOLD_CYC, 16, minimum cycles out stays high after brout_filt deasserts (>=1)
RECFG_CYC, 8, cycles of blanking after a trip-code change in ARMED (>=1)
CNT_W, 8, width of event counter

Ports:
osc_ck  in  1  clock; one clock domain; reset is synchronous, active-low
rst_n  in  1  synchronous active-low reset
ena  in  1  macro enable, synchronous to osc_ck
cfg_valid  in  1  new trip codes offered
cfg_otrip  in  3  requested otrip code
cfg_vtrip  in  3  requested vtrip code
cfg_ready  out  1  codes accepted this cycle when cfg_valid=1
brout_filt  in  1  filtered brownout comparator output
otrip  out  3  applied otrip code to macro
vtrip  out  3  applied vtrip code to macro
blank  out  1  comparator path blanked (settling)
out  out  1  gated/stretched brownout flag
event_cnt  out  CNT_W  saturating count of brownout events
irq  out  1  sticky event interrupt
irq_clr  in  1  clears irq
cnt_clr  in  1  clears event_cnt

Behaviour:
- Reset (rst_n=0 at a rising edge): state=OFF, otrip=vtrip=3'b000, blank=0, out=0, event_cnt=0, irq=0, timer=0. All outputs are registered except cfg_ready.
- States: OFF, SETTLE, ARMED, TRIPPED, HOLD, RECONFIG. A single down-counter (timer) is shared, sized for max(SETTLE_CYC, HOLD_CYC, RECFG_CYC).
- ena=0 in any state: next state OFF, blank=0, out=0. Codes, event_cnt and irq are retained. Highest priority after reset.
- OFF: out=0, blank=0. ena=1 -> SETTLE with timer=SETTLE_CYC-1.
- SETTLE: blank=1, out=1 (safe default during startup). brout_filt is ignored. Decrement timer; at timer==0 -> ARMED. blank and out drop on the cycle ARMED is entered, so SETTLE lasts exactly SETTLE_CYC cycles.
- ARMED: blank=0, out=0.
  - brout_filt=1 -> TRIPPED: out=1 next cycle; event_cnt+1 (saturates at all-ones); irq=1.
  - Otherwise, a cfg handshake -> RECONFIG with timer=RECFG_CYC-1.
- TRIPPED: out=1. brout_filt=0 -> HOLD with timer=HOLD_CYC-1.
- HOLD: out=1.
  - brout_filt=1 -> TRIPPED. This is the same event, so there is no new count.
  - Else at timer==0 -> ARMED, and out=0 on entry.
- RECONFIG: blank=1. out holds 0 and brout_filt is ignored. At timer==0 -> ARMED.
- cfg_ready (combinational) = (state==OFF) | (state==ARMED & ~brout_filt & ena).
- Handshake is cfg_valid & cfg_ready. Codes are registered onto otrip/vtrip on the next edge.
  - In OFF: codes update, state stays OFF.
  - In ARMED: codes update together with entry to RECONFIG.
- Simultaneous events:
  - brout_filt=1 and cfg_valid in ARMED: brownout wins, codes are not taken, requester keeps cfg_valid.
  - irq set and irq_clr in the same cycle: irq=1.
  - Event increment and cnt_clr in the same cycle: event_cnt=1.
  - ena falling during SETTLE/RECONFIG/HOLD: abort to OFF, timer discarded. A later ena rise restarts the full SETTLE.
- Reset mid-operation returns every output to its reset value on that edge, including applied codes.

Decomposition:
- Package brownout_pkg: state enum (brownout_seq_state_t, 3-bit encoding), trip-code typedef (logic [2:0]), default code constants (OTRIP_RST, VTRIP_RST = 3'b000).
- The sub-module brownout_evt_cnt (saturating counter + sticky irq with clear) is natural. Everything else stays in brownout_seq.

Test Plan:
1. Power-up: rst_n released, ena=1 with brout_filt=0 -> blank=1 and out=1 for exactly 64 cycles, then blank=0, out=0, cfg_ready=1.
2. Event + hold: in ARMED, pulse brout_filt=1 for 3 cycles -> out=1 for 3+16 cycles, event_cnt=1, irq=1. Re-assert brout_filt at hold cycle 10 -> out stays high, event_cnt stays 1.
3. Reconfig: in ARMED, cfg_valid with otrip=3'b101, vtrip=3'b011 -> cfg_ready=1, codes applied next cycle, blank=1 for 8 cycles, brout_filt pulses during blank are ignored (event_cnt unchanged).
4. Collision: brout_filt=1 and cfg_valid in the same ARMED cycle -> cfg_ready=0, codes unchanged, TRIPPED. Hold cfg_valid -> accepted on the first ARMED cycle after the hold expires.
5. Saturation/clear: 260 events with CNT_W=8 -> event_cnt=255. Event and cnt_clr in the same cycle -> 1. irq_clr together with a new event -> irq stays 1.
6. Abort: ena=0 at SETTLE cycle 20, then ena=1 -> blank lasts a fresh 64 cycles. rst_n=0 in HOLD -> out=0, codes=000, event_cnt=0 on that edge.

Source files
------------

// File: rtl/brownout_pkg.sv
// brownout_pkg: shared types and constants for the brownout sequencer
package brownout_pkg;
    typedef enum logic [2:0] {
        OFF      = 3'd0,
        SETTLE   = 3'd1,
        ARMED    = 3'd2,
        TRIPPED  = 3'd3,
        HOLD     = 3'd4,
        RECONFIG = 3'd5
    } brownout_seq_state_t;
    typedef logic [2:0] trip_t;
    localparam trip_t OTRIP_RST = 3'b000;
    localparam trip_t VTRIP_RST = 3'b000;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/brownout_seq_if.sv
// brownout_seq_if: trip-code valid/ready handshake between requester and sequencer
interface brownout_seq_if;
    import brownout_pkg::*;
    logic  valid;
    logic  ready;
    trip_t otrip;
    trip_t vtrip;
    modport master(output valid, otrip, vtrip, input ready);
    modport slave(input valid, otrip, vtrip, output ready);
endinterface

// File: rtl/brownout_evt_cnt.sv
// brownout_evt_cnt: saturating event counter with sticky interrupt and clears
module brownout_evt_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             osc_ck,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             cnt_clr,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] event_cnt,
    output logic             irq
);
    // a new event always beats a same-cycle clear
    always_ff @(posedge osc_ck) begin
        if (!rst_n) begin
            event_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            if (cnt_clr)
                event_cnt <= inc ? CNT_W'(1) : '0;
            else if (inc && event_cnt != '1)
                event_cnt <= event_cnt + 1'b1;
            irq <= inc ? 1'b1 : irq_clr ? 1'b0 : irq;
        end
    end
endmodule

// File: rtl/brownout_seq.sv
// brownout_seq: trip-code apply, settle blanking, event stretch and counting
module brownout_seq
    import brownout_pkg::*;
#(
    parameter int SETTLE_CYC = 64,
    parameter int HOLD_CYC   = 16,
    parameter int RECFG_CYC  = 8,
    parameter int CNT_W      = 8
) (
    input  logic               osc_ck,
    input  logic               rst_n,
    input  logic               ena,
    brownout_seq_if.slave      cfg,
    input  logic               brout_filt,
    output trip_t              otrip,
    output trip_t              vtrip,
    output logic               blank,
    output logic               out,
    output logic [CNT_W-1:0]   event_cnt,
    output logic               irq,
    input  logic               irq_clr,
    input  logic               cnt_clr
);
    localparam int TW = $clog2(max3(SETTLE_CYC, HOLD_CYC, RECFG_CYC) + 1);

    brownout_seq_state_t state;
    logic [TW-1:0]       timer;
    logic                hs;
    logic                trip;

    assign cfg.ready = (state == OFF) || (state == ARMED && !brout_filt && ena);
    assign hs        = cfg.valid && cfg.ready;
    assign trip      = ena && state == ARMED && brout_filt;

    always_ff @(posedge osc_ck) begin
        if (!rst_n) begin
            state <= OFF;
            timer <= '0;
            otrip <= OTRIP_RST;
            vtrip <= VTRIP_RST;
            blank <= 1'b0;
            out   <= 1'b0;
        end else begin
            if (hs) begin
                otrip <= cfg.otrip;
                vtrip <= cfg.vtrip;
            end
            if (!ena) begin
                state <= OFF;
                timer <= '0;
                blank <= 1'b0;
                out   <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state <= SETTLE;
                        timer <= TW'(SETTLE_CYC - 1);
                        blank <= 1'b1;
                        out   <= 1'b1;
                    end
                    SETTLE:
                        if (timer == '0) begin
                            state <= ARMED;
                            blank <= 1'b0;
                            out   <= 1'b0;
                        end else timer <= timer - 1'b1;
                    ARMED:
                        if (brout_filt) begin
                            state <= TRIPPED;
                            out   <= 1'b1;
                        end else if (hs) begin
                            state <= RECONFIG;
                            timer <= TW'(RECFG_CYC - 1);
                            blank <= 1'b1;
                        end
                    TRIPPED:
                        if (!brout_filt) begin
                            state <= HOLD;
                            timer <= TW'(HOLD_CYC - 1);
                        end
                    HOLD:
                        if (brout_filt) state <= TRIPPED;
                        else if (timer == '0) begin
                            state <= ARMED;
                            out   <= 1'b0;
                        end else timer <= timer - 1'b1;
                    RECONFIG:
                        if (timer == '0) begin
                            state <= ARMED;
                            blank <= 1'b0;
                        end else timer <= timer - 1'b1;
                    default: begin
                        state <= OFF;
                        blank <= 1'b0;
                        out   <= 1'b0;
                    end
                endcase
            end
        end
    end

    brownout_evt_cnt #(.CNT_W(CNT_W)) u_evt (
        .osc_ck    (osc_ck),
        .rst_n     (rst_n),
        .inc       (trip),
        .cnt_clr   (cnt_clr),
        .irq_clr   (irq_clr),
        .event_cnt (event_cnt),
        .irq       (irq)
    );
endmodule
